scan_seq_ctrl: RTL and testbench

On-chip scan test sequencer for the chip top. It unlocks scan test mode through a serial key shifted in on the SDA pad while TST is held high. After unlock, it runs a programmed number of scan patterns. Each pattern is a shift phase with scan_en high, then a capture phase with cap_en high, ending with a final unload shift. It sits between the pad-side test inputs (TST, SDA, GPIO1) and the scan-enable and capture-clock gating of the core.

---
 rtl/scan_seq_if.sv | 34 +++
 rtl/scan_seq_ctrl.sv | 194 +++++++++++++++++++
 tb/tb_scan_seq_ctrl.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/scan_seq_if.sv
`default_nettype none
// ============================================================================
//  Module      : scan_seq_if
//  Description : Pad-side test inputs and scan-control outputs of the scan
//                test sequencer, bundled with master (pad/test side) and
//                slave (sequencer) views.
//  Revision    : 1.0 - initial release
// ============================================================================
interface scan_seq_if #(
    parameter int CNT_W = 8
);
    logic             tst_in;
    logic             sdi;
    logic             start;
    logic [CNT_W-1:0] pat_num;
    logic             test_mode;
    logic             scan_en;
    logic             cap_en;
    logic             busy;
    logic             done;
    logic [9:0]       shift_cnt;
    logic [CNT_W-1:0] pat_cnt;

    modport master (
        output tst_in, sdi, start, pat_num,
        input  test_mode, scan_en, cap_en, busy, done, shift_cnt, pat_cnt
    );

    modport slave (
        input  tst_in, sdi, start, pat_num,
        output test_mode, scan_en, cap_en, busy, done, shift_cnt, pat_cnt
    );
endinterface
`default_nettype wire

// File: rtl/scan_seq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : scan_seq_ctrl
//  Description : Scan test sequencer. Unlocks test mode with a serial key on
//                sdi while tst_in is high, then runs pat_num shift/capture
//                pairs followed by a final unload shift.
//  Revision    : 1.0 - initial release
// ============================================================================
module scan_seq_ctrl #(
    parameter int         CHAIN_LEN = 64,
    parameter int         CAP_CYC   = 1,
    parameter logic [7:0] KEY       = 8'hA5,
    parameter int         CNT_W     = 8
) (
    input  wire logic     clk,
    input  wire logic     rst,
    scan_seq_if.slave     bus
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_KEY   = 3'd1,
        S_LOCK  = 3'd2,
        S_ARMED = 3'd3,
        S_SHIFT = 3'd4,
        S_CAPT  = 3'd5
    } state_t;

    localparam logic [9:0] c_shift_last = 10'(CHAIN_LEN - 1);
    localparam logic [1:0] c_cap_last   = 2'(CAP_CYC - 1);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [6:0]       r_key;
    logic [2:0]       r_bit_cnt;
    logic [9:0]       r_shift_cnt;
    logic [1:0]       r_cap_cnt;
    logic [CNT_W-1:0] r_pat_lat;
    logic [CNT_W-1:0] r_pat_cnt;
    logic             r_test_mode;
    logic             r_scan_en;
    logic             r_cap_en;
    logic             r_busy;
    logic             r_done;

    logic             w_done_nxt;
    logic             w_accept;
    logic [7:0]       w_key_full;
    logic             w_shift_end;
    logic             w_capt_end;

    // Key byte including the bit arriving this cycle (MSB first)
    assign w_key_full  = {r_key, bus.sdi};
    assign w_shift_end = (r_shift_cnt == c_shift_last);
    assign w_capt_end  = (r_cap_cnt == c_cap_last);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode; tst_in low outranks start and phase ends
    always_comb begin
        w_state_nxt = r_state;
        w_done_nxt  = 1'b0;
        w_accept    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.tst_in) w_state_nxt = S_KEY;
            end
            S_KEY: begin
                if (!bus.tst_in)
                    w_state_nxt = S_IDLE;
                else if (r_bit_cnt == 3'd7)
                    w_state_nxt = (w_key_full == KEY) ? S_ARMED : S_LOCK;
            end
            S_LOCK: begin
                if (!bus.tst_in) w_state_nxt = S_IDLE;
            end
            S_ARMED: begin
                if (!bus.tst_in) begin
                    w_state_nxt = S_IDLE;
                end else if (bus.start) begin
                    if (bus.pat_num != '0) begin
                        w_state_nxt = S_SHIFT;
                        w_accept    = 1'b1;
                    end else begin
                        w_done_nxt  = 1'b1;
                    end
                end
            end
            S_SHIFT: begin
                if (!bus.tst_in) begin
                    w_state_nxt = S_IDLE;
                end else if (w_shift_end) begin
                    if (r_pat_cnt < r_pat_lat) begin
                        w_state_nxt = S_CAPT;
                    end else begin
                        // final unload finished
                        w_state_nxt = S_ARMED;
                        w_done_nxt  = 1'b1;
                    end
                end
            end
            S_CAPT: begin
                if (!bus.tst_in)
                    w_state_nxt = S_IDLE;
                else if (w_capt_end)
                    w_state_nxt = S_SHIFT;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Key shift register and bit counter; both cleared outside KEY
    always_ff @(posedge clk) begin
        if (rst) begin
            r_key     <= '0;
            r_bit_cnt <= '0;
        end else if (r_state == S_KEY) begin
            r_key     <= w_key_full[6:0];
            r_bit_cnt <= r_bit_cnt + 3'd1;
        end else begin
            r_key     <= '0;
            r_bit_cnt <= '0;
        end
    end

    // Phase counters restart on every entry into their phase
    always_ff @(posedge clk) begin
        if (rst) begin
            r_shift_cnt <= '0;
            r_cap_cnt   <= '0;
        end else begin
            if (r_state == S_SHIFT && w_state_nxt == S_SHIFT)
                r_shift_cnt <= r_shift_cnt + 10'd1;
            else
                r_shift_cnt <= '0;
            if (r_state == S_CAPT && w_state_nxt == S_CAPT)
                r_cap_cnt <= r_cap_cnt + 2'd1;
            else
                r_cap_cnt <= '0;
        end
    end

    // Pattern count latch and completed-capture counter
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pat_lat <= '0;
            r_pat_cnt <= '0;
        end else begin
            if (w_accept)
                r_pat_lat <= bus.pat_num;
            if (w_state_nxt == S_IDLE)
                r_pat_cnt <= '0;
            else if (w_accept)
                r_pat_cnt <= '0;
            else if (r_state == S_CAPT && w_state_nxt == S_SHIFT)
                r_pat_cnt <= r_pat_cnt + 1'b1;
        end
    end

    // Registered state-decoded outputs, computed from the next state
    always_ff @(posedge clk) begin
        if (rst) begin
            r_test_mode <= 1'b0;
            r_scan_en   <= 1'b0;
            r_cap_en    <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_test_mode <= (w_state_nxt == S_ARMED) || (w_state_nxt == S_SHIFT) ||
                           (w_state_nxt == S_CAPT);
            r_scan_en   <= (w_state_nxt == S_SHIFT);
            r_cap_en    <= (w_state_nxt == S_CAPT);
            r_busy      <= (w_state_nxt == S_SHIFT) || (w_state_nxt == S_CAPT);
            r_done      <= w_done_nxt;
        end
    end

    assign bus.test_mode = r_test_mode;
    assign bus.scan_en   = r_scan_en;
    assign bus.cap_en    = r_cap_en;
    assign bus.busy      = r_busy;
    assign bus.done      = r_done;
    assign bus.shift_cnt = r_shift_cnt;
    assign bus.pat_cnt   = r_pat_cnt;

endmodule
`default_nettype wire

// File: tb/tb_scan_seq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_scan_seq_ctrl
//  Description : Scoreboard bench for scan_seq_ctrl. The driver pushes the
//                expected output word for each clock it drives; the monitor
//                pops and compares on the falling edge.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_scan_seq_ctrl;

    localparam int         CL   = 64;
    localparam int         CC   = 1;
    localparam int         CW   = 8;
    localparam logic [7:0] KEYV = 8'hA5;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    scan_seq_if #(.CNT_W(CW)) bus();

    scan_seq_ctrl #(
        .CHAIN_LEN (CL),
        .CAP_CYC   (CC),
        .KEY       (KEYV),
        .CNT_W     (CW)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Output word: {test_mode, scan_en, cap_en, busy, done, shift_cnt, pat_cnt}
    typedef struct packed {
        int          cyc;
        logic [22:0] vec;
    } exp_t;

    exp_t exp_q[$];
    int   cyc   = 0;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   m_pc  = 0;
    bit   m_armed = 1'b0;

    logic [22:0] w_got;
    assign w_got = {bus.test_mode, bus.scan_en, bus.cap_en, bus.busy, bus.done,
                    bus.shift_cnt, bus.pat_cnt};

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: compare every expectation due in the current cycle
    always @(negedge clk) begin
        exp_t e;
        while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
            e = exp_q.pop_front();
            n_cmp++;
            if (w_got !== e.vec) begin
                n_bad++;
                $display("FAIL outputs cyc=%0d got tm/se/ce/bz/dn=%b sc=%0d pc=%0d expected tm/se/ce/bz/dn=%b sc=%0d pc=%0d",
                         cyc, w_got[22:18], w_got[17:8], w_got[7:0],
                         e.vec[22:18], e.vec[17:8], e.vec[7:0]);
            end
        end
    end

    function automatic logic [22:0] ev(bit tm, bit se, bit ce, bit bz, bit dn,
                                       int sc, int pc);
        return {tm, se, ce, bz, dn, 10'(sc), 8'(pc)};
    endfunction

    // Expect v after the coming rising edge, then step past it
    task automatic tick(logic [22:0] v);
        exp_t e;
        e.cyc = cyc + 1;
        e.vec = v;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    // Raise tst_in from IDLE and shift a key byte MSB first
    task automatic enter_key(logic [7:0] k);
        bus.tst_in = 1'b1;
        bus.start  = 1'b0;
        bus.sdi    = 1'($urandom_range(0, 1));
        tick(23'd0);
        for (int i = 7; i >= 0; i--) begin
            bus.sdi = k[i];
            tick((i == 0) ? ev(k == KEYV, 0, 0, 0, 0, 0, 0) : 23'd0);
        end
        m_armed = (k == KEYV);
        m_pc    = 0;
    endtask

    // Key bits sent while locked are ignored
    task automatic send_locked(logic [7:0] k);
        bus.tst_in = 1'b1;
        for (int i = 7; i >= 0; i--) begin
            bus.sdi = k[i];
            tick(23'd0);
        end
    endtask

    // tst_in low: everything at reset values, start pulses ignored
    task automatic drop_tst(int n);
        for (int i = 0; i < n; i++) begin
            bus.tst_in  = 1'b0;
            bus.start   = 1'($urandom_range(0, 1));
            bus.pat_num = 8'($urandom_range(1, 255));
            tick(23'd0);
        end
        m_armed = 1'b0;
        m_pc    = 0;
    endtask

    task automatic armed_idle(int n);
        for (int i = 0; i < n; i++) begin
            bus.tst_in = 1'b1;
            bus.start  = 1'b0;
            bus.sdi    = 1'($urandom_range(0, 1));
            tick(ev(1, 0, 0, 0, 0, 0, m_pc));
        end
    endtask

    // Start a run of n patterns; abort_at >= 0 drops tst_in at that step
    task automatic run(int n, int abort_at);
        logic [22:0] tr[$];
        if (n == 0) begin
            tr.push_back(ev(1, 0, 0, 0, 1, 0, m_pc));
        end else begin
            for (int p = 0; p <= n; p++) begin
                for (int i = 0; i < CL; i++) tr.push_back(ev(1, 1, 0, 1, 0, i, p));
                if (p < n)
                    for (int c = 0; c < CC; c++) tr.push_back(ev(1, 0, 1, 1, 0, 0, p));
            end
            tr.push_back(ev(1, 0, 0, 0, 1, 0, n));
        end
        for (int j = 0; j < tr.size(); j++) begin
            bus.sdi = 1'($urandom_range(0, 1));
            if (j == abort_at) begin
                bus.tst_in = 1'b0;
                bus.start  = 1'($urandom_range(0, 1));
                tick(23'd0);
                m_pc    = 0;
                m_armed = 1'b0;
                return;
            end
            bus.tst_in = 1'b1;
            if (j == 0) begin
                bus.start   = 1'b1;
                bus.pat_num = 8'(n);
            end else begin
                // always poke start while the DUT sits in a capture cycle
                bus.start   = tr[j-1][20] ? 1'b1 : 1'($urandom_range(0, 1));
                bus.pat_num = 8'($urandom_range(0, 255));
            end
            tick(tr[j]);
        end
        if (n != 0) m_pc = n;
    endtask

    initial begin
        int n;
        int len;
        int ab;
        logic [7:0] k;

        rst         = 1'b1;
        bus.tst_in  = 1'b1;
        bus.sdi     = 1'b0;
        bus.start   = 1'b0;
        bus.pat_num = '0;
        tick(23'd0);
        tick(23'd0);
        rst = 1'b0;

        enter_key(KEYV);
        armed_idle(3);
        run(0, -1);
        armed_idle(2);
        run(3, -1);
        armed_idle(3);

        drop_tst(1);
        enter_key(8'hA4);
        send_locked(KEYV);
        drop_tst(1);
        enter_key(KEYV);
        armed_idle(1);

        // abort while shift_cnt shows 20 in the second shift window
        run(3, CL + CC + 20 + 1);
        drop_tst(4);
        enter_key(KEYV);
        run(2, -1);
        armed_idle(2);

        for (int it = 0; it < 12; it++) begin
            if (!m_armed) begin
                drop_tst($urandom_range(1, 3));
                k = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255)) : KEYV;
                enter_key(k);
            end
            if (m_armed) begin
                n   = $urandom_range(0, 5);
                len = (n == 0) ? 1 : (n + 1) * CL + n * CC + 1;
                ab  = ($urandom_range(0, 3) == 0) ? $urandom_range(0, len - 1) : -1;
                run(n, ab);
                if (m_armed) armed_idle($urandom_range(1, 4));
            end
        end
        drop_tst(2);

        @(negedge clk);
        #1;
        if (exp_q.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL scoreboard_drain got %0d pending expected 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
